// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full/level controller for the asynchronous FIFO.
// Define WPTR_FULL_AFULL_EN to build the almost-full register and comparator.
module wptr_full_ctrl #(
   parameter int unsigned ADDR_WIDTH   = 3,
   parameter int unsigned AFULL_THRESH = 6
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic                  winc_i,
   input  logic [ADDR_WIDTH:0]   wq2_rptr_i,
   input  logic                  wovf_clr_i,
   output logic                  wen_o,
   output logic [ADDR_WIDTH-1:0] waddr_o,
   output logic [ADDR_WIDTH:0]   wptr_o,
   output logic                  wfull_o,
   output logic [ADDR_WIDTH:0]   wlevel_o,
   output logic                  wafull_o,
   output logic                  wovf_o
);

   localparam int unsigned AW = ADDR_WIDTH;

   typedef logic [AW:0] ptr_t;

   ptr_t wbin_q, wbin_d;
   ptr_t wptr_q, wptr_d;
   ptr_t wlevel_q, wlevel_d;
   ptr_t rbin;
   logic wfull_q, wfull_d;
   logic wovf_q, wovf_d;
   logic wen;

   // Gray-to-binary of the synchronized read pointer: each bit is the XOR of itself and all
   // more significant Gray bits.
   always_comb begin
      rbin = '0;
      for (int i = 0; i <= int'(AW); i++) begin
         rbin[i] = ^(wq2_rptr_i >> i);
      end
   end

   // Writes are gated by the registered full flag, so a write into a full FIFO is dropped.
   always_comb begin
      wen      = winc_i & ~wfull_q;
      wbin_d   = wbin_q + ptr_t'(wen);
      wptr_d   = (wbin_d >> 1) ^ wbin_d;
      wfull_d  = (wptr_d == {~wq2_rptr_i[AW:AW-1], wq2_rptr_i[AW-2:0]});
      wlevel_d = wbin_d - rbin;
      // Set wins over clear when both happen in the same cycle.
      wovf_d   = (winc_i & wfull_q) | (wovf_q & ~wovf_clr_i);
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_q   <= '0;
         wptr_q   <= '0;
         wfull_q  <= 1'b0;
         wlevel_q <= '0;
         wovf_q   <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wptr_q   <= wptr_d;
         wfull_q  <= wfull_d;
         wlevel_q <= wlevel_d;
         wovf_q   <= wovf_d;
      end
   end

`ifdef WPTR_FULL_AFULL_EN
   logic wafull_q, wafull_d;

   always_comb begin
      wafull_d = (wlevel_d >= ptr_t'(AFULL_THRESH));
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wafull_q <= 1'b0;
      end else begin
         wafull_q <= wafull_d;
      end
   end

   assign wafull_o = wafull_q;
`else
   logic unused_afull_thresh;
   assign unused_afull_thresh = ^AFULL_THRESH;
   assign wafull_o            = 1'b0;
`endif

   assign wen_o    = wen;
   assign waddr_o  = wbin_q[AW-1:0];
   assign wptr_o   = wptr_q;
   assign wfull_o  = wfull_q;
   assign wlevel_o = wlevel_q;
   assign wovf_o   = wovf_q;

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-domain pointer and full-flag controller for the asynchronous FIFO. It consumes the double-synchronized Gray read pointer from the read-to-write synchronizer and maintains the binary and Gray write pointers. It produces the RAM write address, a registered full flag, fill level, almost-full, and a sticky overflow error. Its Gray write pointer output feeds the write-to-read synchronizer.

## Interface
- ADDR_WIDTH, 3, RAM address width; depth = 2^ADDR_WIDTH; must be >= 2.
- AFULL_THRESH, 6, fill level at or above which almost-full asserts; range 1..2^ADDR_WIDTH.
- wclk  in  1  write clock.
- wrst_n  in  1  reset: wrst_n, asynchronous, active-low; clock wclk.
- winc  in  1  write request.
- wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already synchronized to wclk.
- wovf_clr  in  1  clears sticky overflow.
- wen  out  1  RAM write enable, combinational: winc & ~wfull.
- waddr  out  ADDR_WIDTH  RAM write address, registered: wbin[ADDR_WIDTH-1:0].
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer.
- wfull  out  1  registered full flag.
- wlevel  out  ADDR_WIDTH+1  registered fill level, 0..2^ADDR_WIDTH.
- wafull  out  1  registered almost-full flag.
- wovf  out  1  sticky overflow; set when winc is asserted while wfull=1.

## Operation
- Internal binary pointer wbin, width ADDR_WIDTH+1.
- wbin_next = wbin + (winc & ~wfull), modulo 2^(ADDR_WIDTH+1).
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- Each edge: wbin <= wbin_next and wptr <= wgray_next.
- Full: wfull <= (wgray_next == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]}), where AW = ADDR_WIDTH.
- Level:
  - rbin_w = Gray-to-binary of wq2_rptr (prefix XOR from the MSB).
  - wlevel <= wbin_next - rbin_w, modulo 2^(AW+1).
- Almost-full: wafull <= (wbin_next - rbin_w) >= AFULL_THRESH.
- Overflow:
  - wovf <= (winc & wfull) | (wovf & ~wovf_clr).
  - Set has priority when set and clear occur in the same cycle.
  - An overflowing write is dropped: pointers do not move and wen=0.
- Full and level are pessimistic. Read-side frees become visible only after the synchronizer latency, so wfull may stay asserted after the FIFO has space. It never deasserts early.
- No state machine beyond the pointer registers. Pointer wrap-around is natural modulo arithmetic. The extra MSB distinguishes full from empty.

## Timing
- Reset values: wbin=0, wptr=0, waddr=0, wfull=0, wlevel=0, wafull=0, wovf=0.
- wen follows winc combinationally, gated by the registered wfull.
- A write is accepted on the rising edge where wen=1. waddr, wptr, and wlevel update on that same edge.
- wfull asserts on the same edge as the write that fills the last entry. A write on the following cycle is blocked.
- A change in wq2_rptr is reflected in wfull, wlevel, and wafull at the next wclk edge (1 cycle).
- Simultaneous write and wq2_rptr advance: both are used in the same edge computation, so the level is unchanged.
- Reset mid-operation: all registers return to their reset values immediately and asynchronously. The pending write is lost.

## Configuration
- WPTR_FULL_AFULL_EN defined: wafull is computed as specified above.
- WPTR_FULL_AFULL_EN undefined:
  - the wafull register and comparator are not built;
  - wafull is tied to 0;
  - AFULL_THRESH is ignored.

## Test plan
- Reset: assert wrst_n=0 mid-stream -> all outputs 0 immediately; wptr=0000.
- Fill (ADDR_WIDTH=3), wq2_rptr held at 0000, 8 consecutive winc:
  - wafull rises after the 6th write (wlevel=6);
  - after the 8th write: wfull=1, wlevel=8, waddr=0, wptr=1100.
- Overflow: from full, pulse winc -> wen=0, wptr stays 1100, wovf=1 next edge. wovf_clr=1 together with winc=1 -> wovf stays 1. wovf_clr alone -> wovf=0.
- Drain: from full, set wq2_rptr=0001 (Gray 1) -> next edge wfull=0, wlevel=7. Set wq2_rptr=0011 (Gray 2) -> wlevel=6.
- Wrap-around: 20 writes with wq2_rptr tracking 2 entries behind -> wbin wraps past 15 to 0. wfull never asserts, wlevel stays 2, and the wptr sequence is valid Gray code (one bit change per write).
- Simultaneous: at wlevel=4, winc=1 with wq2_rptr advancing by one entry in the same cycle -> wlevel stays 4 and wen=1.
